spi_xfer_sequencer: RTL

Memory-mapped picoRV32 peripheral that sequences multi-byte, full-duplex SPI transactions through the single-byte SPI engine. It buffers TX bytes from the CPU in a FIFO and drives chip-select with programmable setup and hold times. It issues one byte at a time to the engine over a start/done handshake and collects the returned bytes in an RX FIFO. It sits between the CPU memory bus and the byte engine and is the engine's only client.

---
 rtl/spi_seq_pkg.sv | 28 ++
 rtl/spi_seq_fifo.sv | 50 +++++
 rtl/spi_xfer_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared register offsets, CTRL/STATUS bit positions and FSM state encoding
// for the SPI transfer sequencer.
package spi_seq_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_KEEP_CS = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_FULL  = 4;
    localparam int ST_OVERFLOW = 5;
    localparam int ST_DONE     = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous show-ahead FIFO; push and pop in one cycle both take effect.
// Push while full is dropped unless a pop frees the slot in the same cycle.
module spi_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Bus-mapped sequencer framing multi-byte SPI transfers with CS setup/hold around a byte engine.
// Bus acks one cycle after decode; the engine is stalled (no eng_start) while the RX FIFO is full.
module spi_xfer_sequencer #(
    parameter logic [31:0] ADDR       = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CS_SETUP   = 2,
    parameter int          CS_HOLD    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wen,
    output logic        mem_port_ready,
    output logic [31:0] rdata,
    output logic        eng_start,
    output logic [7:0]  eng_tx_byte,
    input  logic        eng_done,
    input  logic [7:0]  eng_rx_byte,
    output logic        cs_n,
    output logic        irq
);
    import spi_seq_pkg::*;

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  tx_hold;
    logic        keep_cs;
    logic        irq_en;
    logic        go_req;
    logic        overflow;
    logic        done;

    logic        acc;
    logic        wr_tx;
    logic        rd_rx;
    logic        wr_ctrl;
    logic        wr_status;
    logic        tx_pop;
    logic        rx_push;
    logic [7:0]  tx_head;
    logic [7:0]  rx_head;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_full;
    logic        rx_empty;
    logic        busy;
    logic [31:0] status;
    logic [31:0] rd_val;
    logic        unused_bits;

    // mem_ready from another slave means this cycle's request is already answered.
    assign acc       = mem_valid && (addr[31:4] == ADDR[31:4]) && !mem_port_ready && !mem_ready;
    assign wr_tx     = acc && wen && (addr[3:0] == OFF_TXDATA);
    assign rd_rx     = acc && !wen && (addr[3:0] == OFF_RXDATA);
    assign wr_ctrl   = acc && wen && (addr[3:0] == OFF_CTRL);
    assign wr_status = acc && wen && (addr[3:0] == OFF_STATUS);
    assign unused_bits = ^wdata[31:8];

    assign busy        = (state != S_IDLE);
    assign tx_pop      = (state == S_ISSUE) && !tx_empty && !rx_full;
    assign eng_start   = tx_pop;
    assign eng_tx_byte = eng_start ? tx_head : tx_hold;
    assign rx_push     = (state == S_WAIT) && eng_done;
    assign irq         = irq_en && done;

    spi_seq_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (wr_tx),
        .push_data (wdata[7:0]),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_seq_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_push),
        .push_data (eng_rx_byte),
        .pop       (rd_rx),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        status              = '0;
        status[ST_BUSY]     = busy;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVERFLOW] = overflow;
        status[ST_DONE]     = done;
    end

    always_comb begin
        rd_val = '0;
        if (addr[3:0] == OFF_RXDATA && !rx_empty)
            rd_val = {23'b0, 1'b1, rx_head};
        else if (addr[3:0] == OFF_STATUS)
            rd_val = status;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            cs_n           <= 1'b1;
            cnt            <= '0;
            tx_hold        <= '0;
            keep_cs        <= 1'b0;
            irq_en         <= 1'b0;
            go_req         <= 1'b0;
            overflow       <= 1'b0;
            done           <= 1'b0;
            mem_port_ready <= 1'b0;
            rdata          <= '0;
        end else begin
            mem_port_ready <= acc;
            rdata          <= (acc && !wen) ? rd_val : 32'h0;
            // go is registered so cs_n falls the cycle after the CTRL ack.
            go_req         <= wr_ctrl && wdata[CTRL_GO];
            if (wr_ctrl) begin
                keep_cs <= wdata[CTRL_KEEP_CS];
                irq_en  <= wdata[CTRL_IRQ_EN];
            end
            if (wr_status && wdata[ST_OVERFLOW]) overflow <= 1'b0;
            if (wr_tx && tx_full && !tx_pop)     overflow <= 1'b1;
            if (wr_status && wdata[ST_DONE])     done     <= 1'b0;
            if (tx_pop) tx_hold <= tx_head;

            case (state)
                S_IDLE: begin
                    if (go_req) begin
                        if (tx_empty) begin
                            cnt   <= 8'(CS_HOLD - 1);
                            state <= S_HOLD;
                        end else if (!cs_n) begin
                            state <= S_ISSUE;
                        end else begin
                            cs_n  <= 1'b0;
                            cnt   <= 8'(CS_SETUP - 1);
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'd0) state <= S_ISSUE;
                    else             cnt   <= cnt - 8'd1;
                end
                S_ISSUE: begin
                    if (tx_empty) begin
                        if (keep_cs) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else if (CS_HOLD == 1) begin
                            cs_n  <= 1'b1;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            // This ISSUE cycle already counts as the first hold cycle.
                            cnt   <= 8'(CS_HOLD - 2);
                            state <= S_HOLD;
                        end
                    end else if (!rx_full) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_done) state <= S_ISSUE;
                end
                S_HOLD: begin
                    if (cnt == 8'd0) begin
                        cs_n  <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
